// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial framing transmitter (start, LSB-first data,
// optional parity, stop bits) with a valid/ready word input.
// Ports:
//   clk, reset_l (sync, active low)
//   in_valid, in_data[DATA_W-1:0], in_ready : word input handshake
//   ser_o      : registered serial line, idles high
//   busy       : frame in progress
//   frame_done : pulse in the final cycle of the last stop bit
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_o,
    output logic              busy,
    output logic              frame_done
);

    // Modes other than 1 (even) and 2 (odd) send no parity bit.
    localparam bit HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam int CW = $clog2(CLKS_PER_BIT > 2 ? CLKS_PER_BIT : 2);
    localparam int BW = $clog2(DATA_W > 2 ? DATA_W : 2);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cyc_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              ser_q;

    logic              bit_end;
    logic              last_stop;
    logic              accept;
    logic [DATA_W-1:0] shift_d;

    assign bit_end   = (cyc_q == CYC_LAST);
    assign last_stop = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
    assign in_ready  = (state_q == S_IDLE) || last_stop;
    assign accept    = in_valid && in_ready;
    assign shift_d   = shift_q >> 1;

    assign ser_o      = ser_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = last_stop;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
        end else if (accept) begin
            // Covers both IDLE and the back-to-back case out of the last stop bit.
            state_q <= S_START;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= in_data;
            par_q   <= (PARITY_MODE == 2) ? ~^in_data : ^in_data;
            ser_q   <= 1'b0;
        end else if (state_q != S_IDLE) begin
            cyc_q <= bit_end ? '0 : cyc_q + 1'b1;
            if (bit_end) begin
                unique case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        ser_q   <= shift_q[0];
                    end
                    S_DATA: begin
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (HAS_PAR) begin
                                state_q <= S_PARITY;
                                ser_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                ser_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_d;
                            ser_q   <= shift_d[0];
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                        ser_q   <= 1'b1;
                    end
                    S_STOP: begin
                        ser_q <= 1'b1;
                        if (bit_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: four parameter variants of serial_frame_tx checked
// cycle by cycle against a bit-list frame model.
module tb_serial_frame_tx;

    localparam int N = 4;
    localparam int DW_A  [N] = '{8, 8, 8, 5};
    localparam int CPB_A [N] = '{4, 1, 2, 3};
    localparam int PM_A  [N] = '{1, 1, 2, 0};
    localparam int SB_A  [N] = '{1, 2, 1, 2};

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        v   [N];
    logic [15:0] d   [N];
    logic        rdy [N];
    logic        ser [N];
    logic        bsy [N];
    logic        fd  [N];

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u0 (
        .clk(clk), .reset_l(reset_l), .in_valid(v[0]), .in_data(d[0][7:0]),
        .in_ready(rdy[0]), .ser_o(ser[0]), .busy(bsy[0]), .frame_done(fd[0]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
        .clk(clk), .reset_l(reset_l), .in_valid(v[1]), .in_data(d[1][7:0]),
        .in_ready(rdy[1]), .ser_o(ser[1]), .busy(bsy[1]), .frame_done(fd[1]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
        .clk(clk), .reset_l(reset_l), .in_valid(v[2]), .in_data(d[2][7:0]),
        .in_ready(rdy[2]), .ser_o(ser[2]), .busy(bsy[2]), .frame_done(fd[2]));
    serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(3), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset_l(reset_l), .in_valid(v[3]), .in_data(d[3][4:0]),
        .in_ready(rdy[3]), .ser_o(ser[3]), .busy(bsy[3]), .frame_done(fd[3]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, built from the bit list.
    function automatic void build(input int k, input logic [15:0] w);
        bit bits[$];
        int ones = 0;
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DW_A[k]; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (PM_A[k] == 1) bits.push_back(bit'(ones % 2));
        if (PM_A[k] == 2) bits.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < SB_A[k]; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c < CPB_A[k]; c++) exp_q.push_back(bits[i]);
    endfunction

    function automatic logic [15:0] rword(input int k);
        return 16'($urandom_range(0, (1 << DW_A[k]) - 1));
    endfunction

    task automatic idle_chk(input int k, input string tag);
        chk({tag, "_ser"}, ser[k], 1'b1);
        chk({tag, "_busy"}, bsy[k], 1'b0);
        chk({tag, "_rdy"}, rdy[k], 1'b1);
        chk({tag, "_fd"}, fd[k], 1'b0);
    endtask

    // Sends n frames with in_valid held, so later words go back-to-back.
    // cut > 0 aborts the first frame with reset at the edge ending cycle cut.
    task automatic send(input int k, input int n, input logic [15:0] w0,
                        input logic [15:0] w1, input int cut);
        logic [15:0] w;
        logic [15:0] nxt;
        int fl;
        string t;
        w = w0;
        @(negedge clk);
        v[k] = 1'b1;
        d[k] = w;
        chk($sformatf("u%0d_rdy_pre", k), rdy[k], 1'b1);
        for (int j = 0; j < n; j++) begin
            build(k, w);
            fl = exp_q.size();
            nxt = (j == 0) ? w1 : rword(k);
            @(posedge clk);
            #1;
            for (int i = 1; i <= fl; i++) begin
                t = $sformatf("u%0d_f%0d_c%0d", k, j, i);
                chk({t, "_ser"}, ser[k], logic'(exp_q[i-1]));
                chk({t, "_busy"}, bsy[k], 1'b1);
                chk({t, "_fd"}, fd[k], logic'(i == fl));
                chk({t, "_rdy"}, rdy[k], logic'(i == fl));
                if (i == 1 && j == n - 1) v[k] = 1'b0;
                d[k] = (i == fl) ? nxt : rword(k);
                if (cut > 0 && i == cut) begin
                    reset_l = 1'b0;
                    v[k] = 1'b0;
                    @(posedge clk);
                    #1;
                    reset_l = 1'b1;
                    idle_chk(k, $sformatf("u%0d_cut", k));
                    return;
                end
                if (i < fl) begin
                    @(posedge clk);
                    #1;
                end
            end
            w = nxt;
        end
        @(posedge clk);
        #1;
        idle_chk(k, $sformatf("u%0d_after", k));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            v[k] = 1'b0;
            d[k] = '0;
        end
        // Reset with in_valid asserted and shifting data: nothing may be accepted.
        v[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            d[0] = rword(0);
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                idle_chk(k, $sformatf("rst%0d_u%0d", c, k));
            end
        end
        @(negedge clk);
        v[0] = 1'b0;
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        idle_chk(0, "post_rst");

        send(0, 1, 16'h00A5, 16'h0000, 0);
        send(2, 1, 16'h0007, 16'h0000, 0);
        send(3, 1, 16'h0007, 16'h0000, 0);
        send(0, 2, 16'h0001, 16'h0080, 0);
        // Mid-frame reset, then quiet cycles with no frame_done, then a clean frame.
        send(0, 1, 16'h00A5, 16'h0000, 20);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            idle_chk(0, $sformatf("quiet%0d", c));
        end
        send(0, 1, 16'h003C, 16'h0000, 0);
        send(1, 1, 16'h00FF, 16'h0000, 0);

        for (int r = 0; r < 12; r++) begin
            int k;
            int n;
            k = int'($urandom_range(0, N - 1));
            n = int'($urandom_range(1, 3));
            send(k, n, rword(k), rword(k), 0);
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
